fetch_stream_unit: RTL and testbench

Parametrised, multi-wide instruction fetch stage with a decoupling instruction queue. It issues FETCH_W-wide requests to a synchronous instruction memory with 1-cycle read latency and writes returned words, tagged with their PCs, into a QDEPTH-entry circular queue. Decode takes 0..ISSUE_W instructions per cycle from the queue head. It sits between the instruction memory and decode. Branch redirects and decode stalls are handled internally without losing or duplicating instructions.

---
 rtl/fetch_pkg.sv | 23 ++
 rtl/instr_queue.sv | 84 ++++++++
 rtl/fetch_stream_unit.sv | 99 +++++++++
 tb/tb_fetch_stream_unit.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared constants, default widths and helpers for the fetch stream unit.
package fetch_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 16;

    localparam logic [DEF_DATA_W-1:0] NOP = 16'h0;

    typedef struct packed {
        logic [DEF_DATA_W-1:0] instr;
        logic [DEF_ADDR_W-1:0] pc;
    } entry_t;

    // Bits needed to hold a count in 0..n.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/instr_queue.sv
// Circular instruction queue: FETCH_W-wide push, ISSUE_W-wide head window.
// Writes land at the clock edge and show on the head window a cycle later.
module instr_queue
    import fetch_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int FETCH_W = 2,
    parameter int ISSUE_W = 2,
    parameter int QDEPTH  = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      wr_en,
    input  logic [FETCH_W*DATA_W-1:0] wr_instr,
    input  logic [ADDR_W-1:0]         wr_pc,
    input  logic [cnt_w(ISSUE_W)-1:0] pop,
    output logic [ISSUE_W-1:0]        valid,
    output logic [ISSUE_W*DATA_W-1:0] rd_instr,
    output logic [ISSUE_W*ADDR_W-1:0] rd_pc,
    output logic [cnt_w(QDEPTH)-1:0]  count
);

    localparam int CNT_W = cnt_w(QDEPTH);
    localparam int PTR_W = ptr_w(QDEPTH);
    localparam logic [DATA_W-1:0] NOP_W = DATA_W'(NOP);

    typedef struct packed {
        logic [DATA_W-1:0] instr;
        logic [ADDR_W-1:0] pc;
    } qent_t;

    qent_t            mem [QDEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (wr_en && !flush) begin
            for (int i = 0; i < FETCH_W; i++) begin
                mem[wr_ptr + PTR_W'(i)] <= '{
                    instr: wr_instr[i*DATA_W +: DATA_W],
                    pc:    wr_pc + ADDR_W'(i)
                };
            end
        end
    end

    // pop is pre-clamped by the caller to the current occupancy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(FETCH_W);
            end
            rd_ptr <= rd_ptr + PTR_W'(pop);
            cnt    <= cnt + (wr_en ? CNT_W'(FETCH_W) : '0) - CNT_W'(pop);
        end
    end

    always_comb begin
        valid    = '0;
        rd_instr = {ISSUE_W{NOP_W}};
        rd_pc    = '0;
        for (int i = 0; i < ISSUE_W; i++) begin
            if (i < int'(cnt)) begin
                valid[i] = 1'b1;
                rd_instr[i*DATA_W +: DATA_W] = mem[rd_ptr + PTR_W'(i)].instr;
                rd_pc[i*ADDR_W +: ADDR_W]    = mem[rd_ptr + PTR_W'(i)].pc;
            end
        end
    end

    assign count = cnt;

endmodule

// File: rtl/fetch_stream_unit.sv
// Multi-wide fetch stage: paced memory requests, epoch-tagged responses,
// and a decoupling queue feeding decode.
module fetch_stream_unit
    import fetch_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int FETCH_W = 2,
    parameter int ISSUE_W = 2,
    parameter int QDEPTH  = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      redirect,
    input  logic [ADDR_W-1:0]         redirect_pc,
    input  logic                      stall,
    input  logic [cnt_w(ISSUE_W)-1:0] dec_take,
    output logic                      imem_req,
    output logic [ADDR_W-1:0]         imem_addr,
    input  logic [FETCH_W*DATA_W-1:0] imem_rdata,
    output logic [ISSUE_W-1:0]        out_valid,
    output logic [ISSUE_W*DATA_W-1:0] out_instr,
    output logic [ISSUE_W*ADDR_W-1:0] out_pc,
    output logic [cnt_w(QDEPTH)-1:0]  q_count
);

    localparam int TAKE_W = cnt_w(ISSUE_W);

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] rsp_pc;
    logic              inflight;
    logic              epoch;
    logic              rsp_epoch;
    logic              fetch_go;
    logic              wr_en;
    logic [TAKE_W-1:0] take;
    int                take_lim;
    int                need;

    always_comb begin
        take_lim = int'(dec_take);
        if (take_lim > int'(q_count)) take_lim = int'(q_count);
        if (take_lim > ISSUE_W) take_lim = ISSUE_W;
        take = stall ? '0 : TAKE_W'(take_lim);
    end

    // Room check counts the response landing this cycle plus the new one.
    always_comb begin
        need = int'(q_count) - int'(take) + FETCH_W;
        if (inflight) need = need + FETCH_W;
        fetch_go = !redirect && (need <= QDEPTH);
    end

    assign imem_req  = reset && fetch_go;
    assign imem_addr = pc;
    assign wr_en     = inflight && (rsp_epoch == epoch) && !redirect;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc        <= RESET_PC;
            rsp_pc    <= '0;
            inflight  <= 1'b0;
            epoch     <= 1'b0;
            rsp_epoch <= 1'b0;
        end else begin
            inflight <= fetch_go;
            if (redirect) begin
                pc    <= redirect_pc;
                epoch <= ~epoch;
            end else if (fetch_go) begin
                pc        <= pc + ADDR_W'(FETCH_W);
                rsp_pc    <= pc;
                rsp_epoch <= epoch;
            end
        end
    end

    instr_queue #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .FETCH_W (FETCH_W),
        .ISSUE_W (ISSUE_W),
        .QDEPTH  (QDEPTH)
    ) u_queue (
        .clk      (clk),
        .reset    (reset),
        .flush    (redirect),
        .wr_en    (wr_en),
        .wr_instr (imem_rdata),
        .wr_pc    (rsp_pc),
        .pop      (take),
        .valid    (out_valid),
        .rd_instr (out_instr),
        .rd_pc    (out_pc),
        .count    (q_count)
    );

endmodule

// File: tb/tb_fetch_stream_unit.sv
// Directed bench for fetch_stream_unit with a 1-cycle synchronous memory
// whose word at address a is 16'hA000 + a.
module tb_fetch_stream_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        stall;
    logic [1:0]  dec_take;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic [1:0]  out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [3:0]  q_count;

    int n_tests = 0;
    int n_fail  = 0;
    logic [15:0] exp_pc;
    int dt;

    always #5 clk = ~clk;

    fetch_stream_unit dut (
        .clk         (clk),
        .reset       (reset),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .stall       (stall),
        .dec_take    (dec_take),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .out_valid   (out_valid),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .q_count     (q_count)
    );

    always @(posedge clk) begin
        if (imem_req) begin
            for (int i = 0; i < 2; i++) begin
                imem_rdata[i*16 +: 16] <= 16'hA000 + imem_addr + 16'(i);
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        redirect = 1'b0;
        redirect_pc = '0;
        stall = 1'b0;
        dec_take = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req", imem_req, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_instr", out_instr, 0);
        chk("rst_pc", out_pc, 0);
        chk("rst_count", q_count, 0);

        // Reset release and streaming at two per cycle.
        nxt();
        reset = 1'b1;
        dec_take = 2'd2;
        #1;
        chk("c0_req", imem_req, 1);
        chk("c0_addr", imem_addr, 16'h0000);
        chk("c0_valid", out_valid, 0);
        nxt();
        chk("c1_valid", out_valid, 0);
        nxt();
        chk("c2_valid", out_valid, 2'b11);
        chk("c2_pc", out_pc, 32'h0001_0000);
        chk("c2_instr", out_instr, 32'hA001_A000);
        for (int k = 3; k <= 6; k++) begin
            nxt();
            chk("strm_pc0", out_pc[15:0], 16'(2 * k - 4));
            chk("strm_in1", out_instr[31:16], 16'hA000 + 16'(2 * k - 3));
            chk("strm_cnt", q_count, 2);
        end

        // Stall fills the queue, then drain one per cycle in order.
        stall = 1'b1;
        #1;
        chk("stall_req", imem_req, 1);
        chk("stall_addr", imem_addr, 16'h000C);
        repeat (9) nxt();
        chk("full_cnt", q_count, 8);
        chk("full_req", imem_req, 0);
        chk("full_pc0", out_pc[15:0], 16'h0008);
        nxt();
        stall = 1'b0;
        dec_take = 2'd1;
        #1;
        chk("drain_req", imem_req, 0);
        for (int k = 0; k < 10; k++) begin
            chk("drain_pc", out_pc[15:0], 16'(8 + k));
            chk("drain_in", out_instr[15:0], 16'hA008 + 16'(k));
            if (k == 1) begin
                chk("drain_addr", imem_addr, 16'h0010);
                chk("drain_req1", imem_req, 1);
            end
            nxt();
        end

        // Redirect, build up to six entries with one in flight, redirect again.
        redirect = 1'b1;
        redirect_pc = 16'h0100;
        dec_take = 2'd0;
        stall = 1'b1;
        #1;
        chk("rd_blk_req", imem_req, 0);
        nxt();
        redirect = 1'b0;
        #1;
        chk("r1_cnt", q_count, 0);
        chk("r1_req", imem_req, 1);
        chk("r1_addr", imem_addr, 16'h0100);
        nxt();
        chk("r2_addr", imem_addr, 16'h0102);
        chk("r2_cnt", q_count, 0);
        nxt();
        chk("r3_cnt", q_count, 2);
        chk("r3_pc0", out_pc[15:0], 16'h0100);
        nxt();
        chk("r4_cnt", q_count, 4);
        nxt();
        chk("r5_cnt", q_count, 6);
        chk("r5_req", imem_req, 0);
        redirect = 1'b1;
        redirect_pc = 16'h0040;
        nxt();
        redirect = 1'b0;
        stall = 1'b0;
        dec_take = 2'd2;
        #1;
        chk("s1_cnt", q_count, 0);
        chk("s1_valid", out_valid, 0);
        chk("s1_req", imem_req, 1);
        chk("s1_addr", imem_addr, 16'h0040);
        nxt();
        chk("s2_cnt", q_count, 0);
        chk("s2_valid", out_valid, 0);
        chk("s2_instr", out_instr, 0);
        nxt();
        chk("s3_valid", out_valid, 2'b11);
        chk("s3_pc", out_pc, 32'h0041_0040);
        chk("s3_instr", out_instr, 32'hA041_A040);
        chk("s3_cnt", q_count, 2);
        dec_take = 2'd3;
        nxt();
        chk("clamp_cnt", q_count, 2);
        chk("clamp_pc0", out_pc[15:0], 16'h0042);

        // Alternating takes walk the pointers around the ring many times.
        exp_pc = 16'h0042;
        for (int i = 0; i < 40; i++) begin
            dt = (i % 2 == 0) ? 1 : 2;
            dec_take = 2'(dt);
            #1;
            chk("ring_pc0", out_pc[15:0], exp_pc);
            chk("ring_pc1", out_pc[31:16], exp_pc + 16'd1);
            chk("ring_in0", out_instr[15:0], 16'hA000 + exp_pc);
            exp_pc = exp_pc + 16'(dt);
            nxt();
        end

        // Address wrap at the top of the space.
        redirect = 1'b1;
        redirect_pc = 16'hFFFF;
        dec_take = 2'd0;
        nxt();
        redirect = 1'b0;
        #1;
        chk("w1_addr", imem_addr, 16'hFFFF);
        chk("w1_req", imem_req, 1);
        nxt();
        chk("w2_addr", imem_addr, 16'h0001);
        nxt();
        chk("w3_cnt", q_count, 2);
        chk("w3_pc", out_pc, 32'h0000_FFFF);
        chk("w3_instr", out_instr, 32'hA000_9FFF);
        dec_take = 2'd1;
        nxt();
        chk("w4_cnt", q_count, 3);
        dec_take = 2'd0;
        nxt();
        chk("w5_cnt", q_count, 5);

        // Asynchronous reset mid-cycle.
        #3;
        reset = 1'b0;
        #1;
        chk("ar_cnt", q_count, 0);
        chk("ar_valid", out_valid, 0);
        chk("ar_instr", out_instr, 0);
        chk("ar_pc", out_pc, 0);
        chk("ar_req", imem_req, 0);
        repeat (2) @(posedge clk);
        nxt();
        reset = 1'b1;
        dec_take = 2'd2;
        #1;
        chk("rr_req", imem_req, 1);
        chk("rr_addr", imem_addr, 16'h0000);
        nxt();
        chk("rr1_valid", out_valid, 0);
        nxt();
        chk("rr2_valid", out_valid, 2'b11);
        chk("rr2_pc", out_pc, 32'h0001_0000);
        chk("rr2_instr", out_instr, 32'hA001_A000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
